// File: rtl/ex_stage_mul_if.sv
// ID/EX operand/control bundle into the execute stage and the registered EX/MEM bundle out of it.
interface ex_stage_mul_if;
  logic [31:0] src_data_a_in;
  logic [31:0] src_data_b_in;
  logic [31:0] imm_value_in;
  logic [4:0]  dest_reg_in;
  logic [31:0] pc_input;
  logic [3:0]  ex_control_in;
  logic        reg_write_en_in;
  logic        mem_write_en_in;
  logic        memory_enable_in;
  logic        flush_in;
  logic [31:0] alu_result_out;
  logic [31:0] store_data_out;
  logic [4:0]  dest_reg_out;
  logic [31:0] pc_out;
  logic        reg_write_en_out;
  logic        mem_write_en_out;
  logic        memory_enable_out;
  logic        ex_stall_out;

  modport master (
    output src_data_a_in, src_data_b_in, imm_value_in, dest_reg_in, pc_input,
           ex_control_in, reg_write_en_in, mem_write_en_in, memory_enable_in, flush_in,
    input  alu_result_out, store_data_out, dest_reg_out, pc_out,
           reg_write_en_out, mem_write_en_out, memory_enable_out, ex_stall_out
  );

  modport slave (
    input  src_data_a_in, src_data_b_in, imm_value_in, dest_reg_in, pc_input,
           ex_control_in, reg_write_en_in, mem_write_en_in, memory_enable_in, flush_in,
    output alu_result_out, store_data_out, dest_reg_out, pc_out,
           reg_write_en_out, mem_write_en_out, memory_enable_out, ex_stall_out
  );
endinterface

// File: rtl/ex_stage_mul.sv
// Execute stage: single-cycle ALU feeding the EX/MEM register, plus an iterative shift-add
// multiplier built only when EX_MUL_EN is defined (otherwise opcode 10 is reserved, no stall).
module ex_stage_mul #(
  parameter int          MUL_BITS_PER_CYCLE = 2,
  parameter logic [31:0] RESET_VALUE        = 32'd0
) (
  input logic           clk,
  input logic           rst,
  ex_stage_mul_if.slave bus
);
  localparam int K = 32 / MUL_BITS_PER_CYCLE;

  logic [31:0] w_opb;
  logic [31:0] w_alu;
  logic [3:0]  w_op;
  logic [4:0]  w_shamt;
  logic        w_mul_hold;
  logic        w_stall;

  logic [31:0] r_alu, r_sd, r_pc;
  logic [4:0]  r_rd;
  logic        r_we, r_mwe, r_men;

  // Memory accesses reuse the adder for address generation with the immediate.
  always_comb begin
    w_opb   = bus.memory_enable_in ? bus.imm_value_in : bus.src_data_b_in;
    w_op    = bus.memory_enable_in ? 4'd0 : bus.ex_control_in;
    w_shamt = w_opb[4:0];
    w_alu   = '0;
    case (w_op)
      4'd0:    w_alu = bus.src_data_a_in + w_opb;
      4'd1:    w_alu = bus.src_data_a_in - w_opb;
      4'd2:    w_alu = bus.src_data_a_in & w_opb;
      4'd3:    w_alu = bus.src_data_a_in | w_opb;
      4'd4:    w_alu = bus.src_data_a_in ^ w_opb;
      4'd5:    w_alu = bus.src_data_a_in << w_shamt;
      4'd6:    w_alu = bus.src_data_a_in >> w_shamt;
      4'd7:    w_alu = $signed(bus.src_data_a_in) >>> w_shamt;
      4'd8:    w_alu = {31'd0, $signed(bus.src_data_a_in) < $signed(w_opb)};
      4'd9:    w_alu = {31'd0, bus.src_data_a_in < w_opb};
      default: w_alu = '0;
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic {S_IDLE, S_BUSY} state_t;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [4:0] CNT_LAST = 5'(K - 1);

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_acc, r_mcand, r_mplier, r_l_sd, r_l_pc;
  logic [4:0]  r_l_rd;
  logic        r_l_we, r_l_mwe;
  logic [31:0] w_pp, w_acc_nxt;
  logic        w_start, w_last;

  assign w_start = (r_state == S_IDLE) && (bus.ex_control_in == OP_MUL) &&
                   bus.reg_write_en_in && !bus.memory_enable_in;
  assign w_last  = (r_state == S_BUSY) && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start) begin w_state_nxt = S_BUSY; w_stall = 1'b1; end
      S_BUSY:  if (w_last) w_state_nxt = S_IDLE; else w_stall = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst || bus.flush_in) begin
      w_state_nxt = S_IDLE;
      w_stall     = 1'b0;
    end
  end

  // Retire MUL_BITS_PER_CYCLE multiplier bits per cycle against the pre-shifted multiplicand.
  always_comb begin
    w_pp = '0;
    for (int j = 0; j < MUL_BITS_PER_CYCLE; j++)
      if (r_mplier[j]) w_pp = w_pp + (r_mcand << j);
  end
  assign w_acc_nxt = r_acc + w_pp;

  always_ff @(posedge clk) begin
    if (rst || bus.flush_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (w_last) begin
        r_cnt <= '0;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 5'd1;
        r_acc <= w_acc_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_mcand  <= bus.src_data_a_in;
      r_mplier <= bus.src_data_b_in;
      r_l_sd   <= bus.src_data_b_in;
      r_l_pc   <= bus.pc_input;
      r_l_rd   <= bus.dest_reg_in;
      r_l_we   <= bus.reg_write_en_in;
      r_l_mwe  <= bus.mem_write_en_in;
    end else if (r_state == S_BUSY) begin
      r_mcand  <= r_mcand << MUL_BITS_PER_CYCLE;
      r_mplier <= r_mplier >> MUL_BITS_PER_CYCLE;
    end
  end

  assign w_mul_hold = w_stall;
`else
  logic [4:0] w_unused_k;
  assign w_unused_k = 5'(K - 1);
  assign w_stall    = 1'b0;
  assign w_mul_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || bus.flush_in || w_mul_hold) begin
      r_alu <= RESET_VALUE;
      r_sd  <= RESET_VALUE;
      r_pc  <= RESET_VALUE;
      r_rd  <= '0;
      r_we  <= 1'b0;
      r_mwe <= 1'b0;
      r_men <= 1'b0;
`ifdef EX_MUL_EN
    end else if (w_last) begin
      r_alu <= w_acc_nxt;
      r_sd  <= r_l_sd;
      r_pc  <= r_l_pc;
      r_rd  <= r_l_rd;
      r_we  <= r_l_we;
      r_mwe <= r_l_mwe;
      r_men <= 1'b0;
`endif
    end else begin
      r_alu <= w_alu;
      r_sd  <= bus.src_data_b_in;
      r_pc  <= bus.pc_input;
      r_rd  <= bus.dest_reg_in;
      r_we  <= bus.reg_write_en_in;
      r_mwe <= bus.mem_write_en_in;
      r_men <= bus.memory_enable_in;
    end
  end

  assign bus.alu_result_out    = r_alu;
  assign bus.store_data_out    = r_sd;
  assign bus.pc_out            = r_pc;
  assign bus.dest_reg_out      = r_rd;
  assign bus.reg_write_en_out  = r_we;
  assign bus.mem_write_en_out  = r_mwe;
  assign bus.memory_enable_out = r_men;
  assign bus.ex_stall_out      = w_stall;
endmodule
